// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG entropy-collection blocks: von Neumann codes,
// default parameter values and a constant-evaluable clog2.
package trng_pkg;

  localparam logic [1:0] VN_OUT0 = 2'b01;
  localparam logic [1:0] VN_OUT1 = 2'b10;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_SAMPLE_DIV  = 4;
  localparam int DEF_VN_EN       = 1;
  localparam int DEF_RCT_CUTOFF  = 16;
  localparam int DEF_FIFO_DEPTH  = 4;

  typedef enum logic {
    PAIR_A = 1'b0,
    PAIR_B = 1'b1
  } pair_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/trng_byte_fifo.sv
// Small synchronous FIFO with registered storage; DEPTH must be a power of two
// (>= 2) so the pointers wrap naturally.
module trng_byte_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [clog2(DEPTH):0]  o_level
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int LW = clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == FULL_LVL);
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full FIFO is still accepted when a pop frees the slot this cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/trng_bit_collector.sv
// Ring-oscillator bit collector: synchronise, sample, health-test, debias,
// pack into bytes and buffer for a valid/ready consumer.
//
// Pair FSM
//   state  | meaning
//   PAIR_A | waiting for first sample of a von Neumann pair
//   PAIR_B | first sample held, next strobe completes the pair
module trng_bit_collector
  import trng_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int VN_EN       = DEF_VN_EN,
  parameter int RCT_CUTOFF  = DEF_RCT_CUTOFF,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enable,
  input  logic                        i_raw_bit,
  output logic [7:0]                  o_byte_out,
  output logic                        o_byte_valid,
  input  logic                        i_byte_ready,
  output logic                        o_health_fail,
  output logic                        o_overflow,
  output logic [clog2(FIFO_DEPTH):0]  o_fifo_level
);

  localparam int DW = (SAMPLE_DIV > 1) ? clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [7:0]    RCT_LIMIT = 8'(RCT_CUTOFF);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_div;
  logic [7:0]             r_rct_cnt;
  logic                   r_prev;
  logic                   r_health_fail;
  logic                   r_overflow;
  pair_state_t            r_pair_state;
  pair_state_t            w_pair_next;
  logic                   r_pair_a;
  logic [6:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_byte_done;
  logic [7:0]             r_byte;

  logic                   w_s_bit;
  logic                   w_strobe;
  logic [7:0]             w_rct_next;
  logic                   w_emit;
  logic                   w_emit_bit;
  logic                   w_fifo_push;
  logic                   w_fifo_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw_bit};
  end
  assign w_s_bit = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable)   r_div <= '0;
    else if (r_div == DIV_LAST) r_div <= '0;
    else                      r_div <= r_div + DW'(1);
  end
  assign w_strobe = i_enable && (r_div == DIV_LAST);

  // A zero count marks "no previous sample", so the next sample restarts at 1.
  always_comb begin
    w_rct_next = 8'd1;
    if (r_rct_cnt != 8'd0 && w_s_bit == r_prev)
      w_rct_next = (r_rct_cnt == 8'hFF) ? r_rct_cnt : r_rct_cnt + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rct_cnt     <= '0;
      r_prev        <= 1'b0;
      r_health_fail <= 1'b0;
    end else if (!i_enable) begin
      r_rct_cnt <= '0;
    end else if (w_strobe) begin
      r_rct_cnt <= w_rct_next;
      r_prev    <= w_s_bit;
      if (w_rct_next == RCT_LIMIT) r_health_fail <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pair_state <= PAIR_A;
      r_pair_a     <= 1'b0;
    end else begin
      r_pair_state <= w_pair_next;
      if (!i_enable)                             r_pair_a <= 1'b0;
      else if (w_strobe && r_pair_state == PAIR_A) r_pair_a <= w_s_bit;
    end
  end

  always_comb begin
    w_pair_next = r_pair_state;
    w_emit      = 1'b0;
    w_emit_bit  = 1'b0;
    if (!i_enable) begin
      w_pair_next = PAIR_A;
    end else if (w_strobe) begin
      if (VN_EN == 0) begin
        w_emit     = 1'b1;
        w_emit_bit = w_s_bit;
      end else begin
        case (r_pair_state)
          PAIR_A: w_pair_next = PAIR_B;
          PAIR_B: begin
            w_pair_next = PAIR_A;
            if ({r_pair_a, w_s_bit} == VN_OUT0) begin
              w_emit     = 1'b1;
              w_emit_bit = 1'b0;
            end else if ({r_pair_a, w_s_bit} == VN_OUT1) begin
              w_emit     = 1'b1;
              w_emit_bit = 1'b1;
            end
          end
          default: w_pair_next = PAIR_A;
        endcase
      end
    end
  end

  // A completed byte is staged for one cycle; dropping enable does not discard it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_done <= 1'b0;
      r_byte      <= '0;
    end else begin
      r_byte_done <= 1'b0;
      if (!i_enable) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_emit) begin
        r_shift   <= {r_shift[5:0], w_emit_bit};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte_done <= 1'b1;
          r_byte      <= {r_shift, w_emit_bit};
        end
      end
    end
  end

  assign o_byte_valid = !w_fifo_empty && !r_health_fail;
  assign w_fifo_pop   = o_byte_valid && i_byte_ready;
  assign w_fifo_push  = r_byte_done && !r_health_fail;

  trng_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_fifo_push),
    .i_push_data (r_byte),
    .i_pop       (w_fifo_pop),
    .o_head      (o_byte_out),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (o_fifo_level)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst)                                          r_overflow <= 1'b0;
    else if (w_fifo_push && w_fifo_full && !w_fifo_pop) r_overflow <= 1'b1;
  end

  assign o_health_fail = r_health_fail;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_trng_bit_collector.sv
// Bench for trng_bit_collector: vector table for VN packing, hand sequences for
// RCT trip, FIFO overflow, push+pop wrap and enable drop; popped bytes scored.
`timescale 1ns/1ps
module tb_trng_bit_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       raw_bit;
  logic       byte_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       health_fail;
  logic       overflow;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] raw;
    int          n;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  trng_bit_collector #(
    .SYNC_STAGES (2),
    .SAMPLE_DIV  (1),
    .VN_EN       (1),
    .RCT_CUTOFF  (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_raw_bit     (raw_bit),
    .o_byte_out    (byte_out),
    .o_byte_valid  (byte_valid),
    .i_byte_ready  (byte_ready),
    .o_health_fail (health_fail),
    .o_overflow    (overflow),
    .o_fifo_level  (fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected byte.
  always begin
    @(negedge clk);
    #1;
    if (!rst && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: actual=0x%0h required=none", byte_out);
      end else begin
        check("pop_order", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [31:0] vn_encode(input logic [7:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) r = {r[29:0], (b[i] ? 2'b10 : 2'b01)};
    return r;
  endfunction

  // Raw bit i is sampled two edges after it is driven, so enable is opened
  // two cycles late and closed right after the last sample.
  task automatic feed(input logic [31:0] raw, input int n, input bit pop_at_push);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i < n) raw_bit = raw[n-1-i];
      enable = (i >= 2);
    end
    @(negedge clk);
    enable = 1'b0;
    if (pop_at_push) byte_ready = 1'b1;
    @(negedge clk);
    if (pop_at_push) byte_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic feed_byte(input logic [7:0] b, input bit pop_at_push);
    feed(vn_encode(b), 16, pop_at_push);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ovf_bytes[5];
    logic [31:0] part;

    rst        = 1'b1;
    enable     = 1'b0;
    raw_bit    = 1'b0;
    byte_ready = 1'b0;

    vecs[0] = '{32'b01101001110010100101, 20, 8'b01101100};
    vecs[1] = '{32'b11100110010001100110, 20, 8'hA5};
    vecs[2] = '{32'b0101010110101010,     16, 8'h0F};
    vecs[3] = '{32'b010110100010100101,   18, 8'h3C};

    // 1: reset and idle with enable low
    do_reset();
    check("rst_valid",  {31'd0, byte_valid},  32'd0);
    check("rst_health", {31'd0, health_fail}, 32'd0);
    check("rst_ovf",    {31'd0, overflow},    32'd0);
    check("rst_level",  {29'd0, fifo_level},  32'd0);
    check("rst_byte",   {24'd0, byte_out},    32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      raw_bit = i[0];
    end
    check("idle_valid",  {31'd0, byte_valid},  32'd0);
    check("idle_level",  {29'd0, fifo_level},  32'd0);
    check("idle_health", {31'd0, health_fail}, 32'd0);

    // 2: VN packing vectors, consumer always ready
    byte_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].exp_b);
      feed(vecs[v].raw, vecs[v].n, 1'b0);
      wait_drain("vec_drain");
      check("vec_level",  {29'd0, fifo_level},  32'd0);
      check("vec_health", {31'd0, health_fail}, 32'd0);
    end
    byte_ready = 1'b0;

    // 3: RCT trip with one byte parked in the FIFO
    do_reset();
    feed_byte(8'h5A, 1'b0);
    check("rct_pre_level", {29'd0, fifo_level}, 32'd1);
    check("rct_pre_valid", {31'd0, byte_valid}, 32'd1);
    @(negedge clk);
    raw_bit = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("rct_15", {31'd0, health_fail}, 32'd0);
    @(posedge clk);
    #1;
    check("rct_16",       {31'd0, health_fail}, 32'd1);
    check("rct_valid",    {31'd0, byte_valid},  32'd0);
    @(negedge clk);
    enable     = 1'b0;
    byte_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("rct_sticky",   {31'd0, health_fail}, 32'd1);
    check("rct_frozen",   {29'd0, fifo_level},  32'd1);
    check("rct_valid2",   {31'd0, byte_valid},  32'd0);
    do_reset();
    check("rct_clr",      {31'd0, health_fail}, 32'd0);
    check("rct_clr_lvl",  {29'd0, fifo_level},  32'd0);

    // 4: overflow with consumer stalled
    ovf_bytes = '{8'hC3, 8'h18, 8'h7E, 8'h81, 8'h99};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(ovf_bytes[i]);
      feed_byte(ovf_bytes[i], 1'b0);
      if (i == 3) check("ovf_not_yet", {31'd0, overflow}, 32'd0);
    end
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_flag",  {31'd0, overflow},   32'd1);
    check("ovf_head",  {24'd0, byte_out},   32'hC3);
    check("ovf_valid", {31'd0, byte_valid}, 32'd1);
    @(negedge clk);
    byte_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_empty",  {29'd0, fifo_level}, 32'd0);
    check("ovf_sticky", {31'd0, overflow},   32'd1);
    @(negedge clk);
    byte_ready = 1'b0;

    // 5: push+pop at level 2 across pointer wrap
    do_reset();
    exp_q.push_back(8'hA1);
    feed_byte(8'hA1, 1'b0);
    exp_q.push_back(8'hB2);
    feed_byte(8'hB2, 1'b0);
    check("pp_level0", {29'd0, fifo_level}, 32'd2);
    exp_q.push_back(8'hC4);
    feed_byte(8'hC4, 1'b1);
    check("pp_level1", {29'd0, fifo_level}, 32'd2);
    exp_q.push_back(8'hD8);
    feed_byte(8'hD8, 1'b1);
    check("pp_level2", {29'd0, fifo_level}, 32'd2);
    exp_q.push_back(8'h6E);
    feed_byte(8'h6E, 1'b1);
    check("pp_level3", {29'd0, fifo_level}, 32'd2);
    check("pp_ovf",    {31'd0, overflow},   32'd0);
    @(negedge clk);
    byte_ready = 1'b1;
    wait_drain("pp_drain");
    check("pp_empty", {29'd0, fifo_level}, 32'd0);
    @(negedge clk);
    byte_ready = 1'b0;

    // 6: enable dropped after five emitted bits
    do_reset();
    exp_q.push_back(8'h96);
    feed_byte(8'h96, 1'b0);
    part = vn_encode(8'hFF) >> 6;
    feed(part, 10, 1'b0);
    check("part_level", {29'd0, fifo_level}, 32'd1);
    exp_q.push_back(8'h03);
    feed_byte(8'h03, 1'b0);
    check("part_level2", {29'd0, fifo_level}, 32'd2);
    @(negedge clk);
    byte_ready = 1'b1;
    wait_drain("part_drain");
    check("part_empty", {29'd0, fifo_level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
